ws2812b_rx: RTL and testbench

WS2812B_RX -- requirements
Module: ws2812b_rx

---
 rtl/ws2812b_pkg.sv | 21 ++
 rtl/ws2812b_rx_if.sv | 13 +
 rtl/ws2812b_din_sync.sv | 31 +++
 rtl/ws2812b_rx.sv | 151 +++++++++++++++
 tb/tb_ws2812b_rx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812b_pkg.sv
// Shared constants, state encoding and helpers for the WS2812B serial receiver.
package ws2812b_pkg;

  localparam int GRB_BITS             = 24;
  localparam int DEFAULT_BIT_THRESH   = 16;
  localparam int DEFAULT_GLITCH_MAX   = 3;
  localparam int DEFAULT_HIGH_MAX     = 40;
  localparam int DEFAULT_LATCH_CYCLES = 1350;

  typedef enum logic [1:0] {
    WAIT_LATCH = 2'd0,
    IDLE       = 2'd1,
    HIGH       = 2'd2,
    LOW        = 2'd3
  } rx_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ws2812b_rx_if.sv
// Decoded-pixel output bundle; master is the receiver, slave is the consumer.
interface ws2812b_rx_if;
  import ws2812b_pkg::*;

  logic [GRB_BITS-1:0] pixel_grb;
  logic                pixel_valid;
  logic [7:0]          pixel_idx;
  logic                frame_done;
  logic                err;

  modport master (output pixel_grb, pixel_valid, pixel_idx, frame_done, err);
  modport slave  (input  pixel_grb, pixel_valid, pixel_idx, frame_done, err);
endinterface

// File: rtl/ws2812b_din_sync.sv
// Two-flop synchronizer for the serial line plus registered rise/fall detect.
module ws2812b_din_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);
  logic meta_reg, sync_reg, dly_reg, rise_reg, fall_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      dly_reg  <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      dly_reg  <= sync_reg;
      rise_reg <= sync_reg & ~dly_reg;
      fall_reg <= ~sync_reg & dly_reg;
    end
  end

  assign din_s = sync_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;
endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver: measures high-pulse widths, assembles 24-bit GRB pixels
// and reports frame latch and protocol errors.
module ws2812b_rx import ws2812b_pkg::*; #(
  parameter int BIT_THRESH   = DEFAULT_BIT_THRESH,
  parameter int GLITCH_MAX   = DEFAULT_GLITCH_MAX,
  parameter int HIGH_MAX     = DEFAULT_HIGH_MAX,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          din,
  ws2812b_rx_if.master  pix
);
  localparam logic [16:0] THRESH_W = 17'(BIT_THRESH);
  localparam logic [16:0] GLITCH_W = 17'(GLITCH_MAX);
  localparam logic [16:0] HIGH_W   = 17'(HIGH_MAX);
  localparam logic [15:0] LATCH_M1 = 16'(LATCH_CYCLES - 1);
  localparam logic [4:0]  LAST_BIT = 5'(GRB_BITS - 1);

  logic din_s, rise, fall;

  ws2812b_din_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (din),
    .din_s     (din_s),
    .rise      (rise),
    .fall      (fall)
  );

  rx_state_t            state_reg, state_next;
  logic [15:0]          cnt_reg, cnt_next;
  logic [4:0]           bit_cnt_reg, bit_cnt_next;
  logic [GRB_BITS-1:0]  shift_reg, shift_next;
  logic [GRB_BITS-1:0]  pixel_grb_reg, pixel_grb_next;
  logic [7:0]           pixel_idx_reg, pixel_idx_next;
  logic                 pixel_valid_reg, pixel_valid_next;
  logic                 frame_done_reg, frame_done_next;
  logic                 err_reg, err_next;

  // Width includes the current cycle, so a pulse of N synchronized samples
  // measures exactly N at its falling edge.
  logic [16:0] width_w;
  logic        too_long, latch_hit, bit_val;
  assign width_w   = {1'b0, cnt_reg} + 17'd1;
  assign too_long  = width_w > HIGH_W;
  assign latch_hit = cnt_reg == LATCH_M1;
  assign bit_val   = width_w >= THRESH_W;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg       <= WAIT_LATCH;
      cnt_reg         <= '0;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      pixel_grb_reg   <= '0;
      pixel_idx_reg   <= '0;
      pixel_valid_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      pixel_grb_reg   <= pixel_grb_next;
      pixel_idx_reg   <= pixel_idx_next;
      pixel_valid_reg <= pixel_valid_next;
      frame_done_reg  <= frame_done_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      WAIT_LATCH: if (!din_s && latch_hit) state_next = IDLE;
      IDLE:       if (rise) state_next = HIGH;
      HIGH: begin
        if (too_long)  state_next = WAIT_LATCH;
        else if (fall) state_next = LOW;
      end
      LOW: begin
        if (rise)           state_next = HIGH;
        else if (latch_hit) state_next = IDLE;
      end
      default: state_next = WAIT_LATCH;
    endcase
  end

  always_comb begin
    cnt_next         = sat_inc16(cnt_reg);
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    pixel_grb_next   = pixel_grb_reg;
    pixel_idx_next   = pixel_idx_reg;
    pixel_valid_next = 1'b0;
    frame_done_next  = 1'b0;
    err_next         = 1'b0;
    if (pixel_valid_reg && pixel_idx_reg != 8'hFF)
      pixel_idx_next = pixel_idx_reg + 8'd1;
    unique case (state_reg)
      WAIT_LATCH: begin
        bit_cnt_next = '0;
        shift_next   = '0;
        if (din_s) cnt_next = '0;
        // A completed resync starts a fresh frame even without a frame_done.
        if (!din_s && latch_hit) pixel_idx_next = '0;
      end
      IDLE: if (rise) cnt_next = '0;
      HIGH: begin
        if (too_long) begin
          err_next     = 1'b1;
          cnt_next     = '0;
          bit_cnt_next = '0;
          shift_next   = '0;
        end else if (fall) begin
          cnt_next = '0;
          if (width_w > GLITCH_W) begin
            shift_next = {shift_reg[GRB_BITS-2:0], bit_val};
            if (bit_cnt_reg == LAST_BIT) begin
              pixel_grb_next   = {shift_reg[GRB_BITS-2:0], bit_val};
              pixel_valid_next = 1'b1;
              bit_cnt_next     = '0;
            end else begin
              bit_cnt_next = bit_cnt_reg + 5'd1;
            end
          end
        end
      end
      LOW: begin
        if (rise) begin
          cnt_next = '0;
        end else if (latch_hit) begin
          frame_done_next = 1'b1;
          err_next        = bit_cnt_reg != 5'd0;
          pixel_idx_next  = '0;
          bit_cnt_next    = '0;
          shift_next      = '0;
        end
      end
      default: ;
    endcase
  end

  assign pix.pixel_grb   = pixel_grb_reg;
  assign pix.pixel_valid = pixel_valid_reg;
  assign pix.pixel_idx   = pixel_idx_reg;
  assign pix.frame_done  = frame_done_reg;
  assign pix.err         = err_reg;
endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed and randomized stimulus for ws2812b_rx; expected pixels come from
// the words the bench itself serializes onto the line.
`timescale 1ns/1ps
module tb_ws2812b_rx;
  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic din       = 1'b0;

  ws2812b_rx_if pix ();

  ws2812b_rx dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (din),
    .pix       (pix)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  int fall_cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Event log filled by the monitor; scenarios look only at what they added.
  logic [31:0] px_q[$];
  int          lat_q[$];
  int          fd_cnt = 0, err_cnt = 0, err_fd_cnt = 0, clash_cnt = 0;

  always @(negedge sys_clk) begin
    if (pix.pixel_valid === 1'b1) begin
      px_q.push_back({pix.pixel_idx, pix.pixel_grb});
      lat_q.push_back(cyc - fall_cyc);
    end
    if (pix.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    if (pix.err === 1'b1) err_cnt <= err_cnt + 1;
    if (pix.err === 1'b1 && pix.frame_done === 1'b1) err_fd_cnt <= err_fd_cnt + 1;
    if (pix.pixel_valid === 1'b1 && pix.frame_done === 1'b1) clash_cnt <= clash_cnt + 1;
  end

  int checks = 0;
  int failures = 0;
  int px0, fd0, err0, efd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    px0  = px_q.size();
    fd0  = fd_cnt;
    err0 = err_cnt;
    efd0 = err_fd_cnt;
  endtask

  task automatic send_level(input logic v, input int n);
    @(posedge sys_clk);
    #1;
    if (din === 1'b1 && v === 1'b0) fall_cyc = cyc;
    din = v;
    repeat (n - 1) @(posedge sys_clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin send_level(1'b1, 22); send_level(1'b0, 12); end
    else   begin send_level(1'b1, 11); send_level(1'b0, 23); end
  endtask

  task automatic send_bit_glitch(input logic b);
    int tl;
    tl = b ? 12 : 23;
    send_level(1'b1, b ? 22 : 11);
    send_level(1'b0, 5);
    send_level(1'b1, 2);
    send_level(1'b0, tl - 7);
  endtask

  task automatic send_pixel(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic latch();
    send_level(1'b0, 1400);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp_q[$],
                             input int exp_fd, input int exp_err, input int exp_efd);
    check({tag, " pixel count"}, 32'(px_q.size() - px0), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (px0 + i < px_q.size()) begin
        check($sformatf("%s grb[%0d]", tag, i), 32'(px_q[px0+i][23:0]), 32'(exp_q[i][23:0]));
        check($sformatf("%s idx[%0d]", tag, i), 32'(px_q[px0+i][31:24]), 32'(exp_q[i][31:24]));
        check($sformatf("%s latency[%0d]", tag, i), 32'(lat_q[px0+i]), 32'd4);
      end
    end
    check({tag, " frame_done"}, 32'(fd_cnt - fd0), 32'(exp_fd));
    check({tag, " err"}, 32'(err_cnt - err0), 32'(exp_err));
    check({tag, " err with frame_done"}, 32'(err_fd_cnt - efd0), 32'(exp_efd));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " pixel_grb"},   32'(pix.pixel_grb),   32'd0);
    check({tag, " pixel_valid"}, 32'(pix.pixel_valid), 32'd0);
    check({tag, " pixel_idx"},   32'(pix.pixel_idx),   32'd0);
    check({tag, " frame_done"},  32'(pix.frame_done),  32'd0);
    check({tag, " err"},         32'(pix.err),         32'd0);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [23:0] w, w_err_next;
    int n;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check_zero("reset");
    sys_rst_n = 1'b1;

    // Startup frame
    latch();
    mark();
    send_pixel(24'h3F3F3F);
    latch();
    exp_q = {};
    exp_q.push_back({8'd0, 24'h3F3F3F});
    check_frame("startup", exp_q, 1, 0, 0);
    $display("txn startup: pixels=%0d frames=%0d", px_q.size() - px0, fd_cnt - fd0);

    // Twelve back-to-back pixels, then a short frame that must restart at idx 0
    mark();
    exp_q = {};
    for (int i = 0; i < 12; i++) begin
      w = 24'($urandom);
      exp_q.push_back({8'(i), w});
      send_pixel(w);
    end
    latch();
    check_frame("multi", exp_q, 1, 0, 0);
    $display("txn multi: pixels=%0d frames=%0d", px_q.size() - px0, fd_cnt - fd0);
    mark();
    exp_q = {};
    for (int i = 0; i < 2; i++) begin
      w = 24'($urandom);
      exp_q.push_back({8'(i), w});
      send_pixel(w);
    end
    latch();
    check_frame("restart", exp_q, 1, 0, 0);
    $display("txn restart: pixels=%0d frames=%0d", px_q.size() - px0, fd_cnt - fd0);

    // Randomly sized frames
    for (int f = 0; f < 3; f++) begin
      mark();
      exp_q = {};
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        w = 24'($urandom);
        exp_q.push_back({8'(i), w});
        send_pixel(w);
      end
      latch();
      check_frame($sformatf("random%0d", f), exp_q, 1, 0, 0);
      $display("txn random%0d: pixels=%0d frames=%0d", f, px_q.size() - px0, fd_cnt - fd0);
    end

    // Short glitch in the low phase of bit 5
    mark();
    w = 24'($urandom);
    for (int i = 23; i >= 0; i--) begin
      if (23 - i == 5) send_bit_glitch(w[i]);
      else             send_bit(w[i]);
    end
    latch();
    exp_q = {};
    exp_q.push_back({8'd0, w});
    check_frame("glitch", exp_q, 1, 0, 0);
    $display("txn glitch: grb=%06h expected=%06h", px_q[px_q.size()-1][23:0], w);

    // Over-long high pulse: resync, then the next frame decodes from idx 0
    mark();
    w = 24'($urandom);
    w_err_next = 24'($urandom);
    send_pixel(w);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    send_level(1'b1, 50);
    send_level(1'b0, 12);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    latch();
    send_pixel(w_err_next);
    latch();
    exp_q = {};
    exp_q.push_back({8'd0, w});
    exp_q.push_back({8'd0, w_err_next});
    check_frame("error", exp_q, 1, 1, 0);
    $display("txn error: pixels=%0d errs=%0d", px_q.size() - px0, err_cnt - err0);

    // Partial pixel at latch
    mark();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    latch();
    exp_q = {};
    check_frame("partial", exp_q, 1, 1, 1);
    check("partial grb hold", 32'(pix.pixel_grb), 32'(w_err_next));
    $display("txn partial: errs=%0d frames=%0d", err_cnt - err0, fd_cnt - fd0);

    // Asynchronous reset at bit 12
    mark();
    w = 24'($urandom);
    for (int i = 23; i >= 12; i--) send_bit(w[i]);
    check("pre-reset grb hold", 32'(pix.pixel_grb), 32'(w_err_next));
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check_zero("async reset");
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    for (int i = 11; i >= 0; i--) send_bit(w[i]);
    latch();
    exp_q = {};
    check_frame("reset inflight", exp_q, 0, 0, 0);
    mark();
    w = 24'($urandom);
    send_pixel(w);
    latch();
    exp_q.push_back({8'd0, w});
    check_frame("post reset", exp_q, 1, 0, 0);
    $display("txn reset: pixels=%0d frames=%0d", px_q.size() - px0, fd_cnt - fd0);

    check("valid/frame_done overlap", 32'(clash_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
